// File: rtl/kl_sim_ram.sv
// Cycle-deterministic KL-bus RAM model: one outstanding request, programmable
// access latency, single-beat writes/reads and 2/4/8-beat incrementing read bursts.
module kl_sim_ram #(
  parameter int          DEPTH_LOG2 = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          LATENCY    = 2,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_req_addr,
  input  logic        bus_req_wen,
  input  logic [63:0] bus_req_wdata,
  input  logic [7:0]  bus_req_wmask,
  input  logic [2:0]  bus_req_size,
  input  logic [4:0]  bus_req_srcid,
  input  logic        bus_req_valid,
  output logic        bus_req_ready,
  output logic [63:0] bus_resp_rdata,
  output logic        bus_resp_ren,
  output logic [2:0]  bus_resp_size,
  output logic [4:0]  bus_resp_dstid,
  output logic        bus_resp_valid,
  input  logic        bus_resp_ready
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            beats_q, beats_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d, req_idx;
  logic                  wen_q, wen_d;
  logic [2:0]            size_q, size_d;
  logic [4:0]            srcid_q, srcid_d;
  logic                  req_hs;
  logic [63:0]           mem_q [DEPTH];

  // Out-of-range addresses simply alias: wrapped 32-bit offset, truncated word index.
  assign req_idx       = DEPTH_LOG2'((bus_req_addr - BASE_ADDR) >> 3);
  assign bus_req_ready = (state_q == S_IDLE);
  assign req_hs        = bus_req_valid && bus_req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beats_d = beats_q;
    idx_d   = idx_q;
    wen_d   = wen_q;
    size_d  = size_q;
    srcid_d = srcid_q;
    case (state_q)
      S_IDLE: if (req_hs) begin
        wen_d   = bus_req_wen;
        size_d  = bus_req_size;
        srcid_d = bus_req_srcid;
        idx_d   = req_idx;
        beats_d = 4'd1;
        if (!bus_req_wen) begin
          case (bus_req_size)
            3'd4:    beats_d = 4'd2;
            3'd5:    beats_d = 4'd4;
            3'd6:    beats_d = 4'd8;
            default: beats_d = 4'd1;
          endcase
        end
        if (LATENCY == 0) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CW'(LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_RESP: if (bus_resp_ready) begin
        if (beats_q == 4'd1) begin
          state_d = S_IDLE;
        end else begin
          beats_d = beats_q - 4'd1;
          idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      beats_q <= '0;
      idx_q   <= '0;
      wen_q   <= 1'b0;
      size_q  <= '0;
      srcid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beats_q <= beats_d;
      idx_q   <= idx_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      srcid_q <= srcid_d;
    end
  end

  // Storage is deliberately not reset; writes land at acceptance, so RAW is coherent.
  always_ff @(posedge clk) begin
    if (!rst && req_hs && bus_req_wen) begin
      for (int b = 0; b < 8; b++) begin
        if (bus_req_wmask[b]) mem_q[req_idx][8*b +: 8] <= bus_req_wdata[8*b +: 8];
      end
    end
  end

  assign bus_resp_valid = (state_q == S_RESP);
  assign bus_resp_ren   = bus_resp_valid & ~wen_q;
  assign bus_resp_rdata = bus_resp_ren ? mem_q[idx_q] : '0;
  assign bus_resp_size  = bus_resp_valid ? size_q  : '0;
  assign bus_resp_dstid = bus_resp_valid ? srcid_q : '0;

endmodule

// File: tb/tb_kl_sim_ram.sv
// Randomized bench for kl_sim_ram: a LATENCY=2 and a LATENCY=0 instance, checked
// every cycle against a word-array/beat-queue model, plus literal directed cases.
module tb_kl_sim_ram;
  localparam int          AW    = 6;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  typedef struct {
    logic [63:0] rdata;
    logic        ren;
    logic [2:0]  size;
    logic [4:0]  dstid;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [31:0] addr = '0;
  logic        wen = 1'b0;
  logic [63:0] wdata = '0;
  logic [7:0]  wmask = '0;
  logic [2:0]  size = '0;
  logic [4:0]  srcid = '0;
  logic        req_v = 1'b0;
  logic        resp_r = 1'b0;

  logic [1:0]  rdy_w, ren_w, vld_w;
  logic [63:0] rdata_w [2];
  logic [2:0]  rsize_w [2];
  logic [4:0]  dstid_w [2];

  kl_sim_ram #(.DEPTH_LOG2(AW), .BASE_ADDR(BASE), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .bus_req_addr(addr), .bus_req_wen(wen), .bus_req_wdata(wdata),
    .bus_req_wmask(wmask), .bus_req_size(size), .bus_req_srcid(srcid),
    .bus_req_valid(req_v && !sel), .bus_req_ready(rdy_w[0]), .bus_resp_rdata(rdata_w[0]),
    .bus_resp_ren(ren_w[0]), .bus_resp_size(rsize_w[0]), .bus_resp_dstid(dstid_w[0]),
    .bus_resp_valid(vld_w[0]), .bus_resp_ready(resp_r && !sel));

  kl_sim_ram #(.DEPTH_LOG2(AW), .BASE_ADDR(BASE), .LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst), .bus_req_addr(addr), .bus_req_wen(wen), .bus_req_wdata(wdata),
    .bus_req_wmask(wmask), .bus_req_size(size), .bus_req_srcid(srcid),
    .bus_req_valid(req_v && sel), .bus_req_ready(rdy_w[1]), .bus_resp_rdata(rdata_w[1]),
    .bus_resp_ren(ren_w[1]), .bus_resp_size(rsize_w[1]), .bus_resp_dstid(dstid_w[1]),
    .bus_resp_valid(vld_w[1]), .bus_resp_ready(resp_r && sel));

  logic        m_ready, m_valid, m_ren;
  logic [63:0] m_rdata;
  logic [2:0]  m_size;
  logic [4:0]  m_dstid;
  assign m_ready = rdy_w[sel];
  assign m_valid = vld_w[sel];
  assign m_ren   = ren_w[sel];
  assign m_rdata = rdata_w[sel];
  assign m_size  = rsize_w[sel];
  assign m_dstid = dstid_w[sel];

  always #5 clk = ~clk;

  // Model state
  logic [63:0] mm [2][DEPTH];
  beat_t       exp_q[$];
  beat_t       log_q[$];
  int          cyc = 0, t_first = 0, acc_cyc = 0, first_lat = 0, beats_done = 0;
  bit          busy = 0, armed = 0, first_pend = 0;
  int          checks = 0, failures = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    bit    was_busy;
    bit    exp_v;
    int    lat, idx, n;
    beat_t b;
    if (rst) begin
      armed = 1;
      busy  = 0;
      exp_q.delete();
    end else if (armed) begin
      lat      = sel ? 0 : 2;
      was_busy = busy;
      exp_v    = busy && (cyc >= t_first);
      chk("req_ready", m_ready, !busy);
      chk("resp_valid", m_valid, exp_v);
      if (m_valid && exp_v && exp_q.size() > 0) begin
        if (first_pend) begin first_lat = cyc - acc_cyc; first_pend = 0; end
        chk("rdata", m_rdata, exp_q[0].rdata);
        chk("ren",   m_ren,   exp_q[0].ren);
        chk("size",  m_size,  exp_q[0].size);
        chk("dstid", m_dstid, exp_q[0].dstid);
        if (resp_r) begin
          b.rdata = m_rdata; b.ren = m_ren; b.size = m_size; b.dstid = m_dstid;
          log_q.push_back(b);
          void'(exp_q.pop_front());
          beats_done++;
          if (exp_q.size() == 0) busy = 0;
        end
      end
      if (req_v && !was_busy) begin
        idx = int'((addr - BASE) >> 3) % DEPTH;
        b.size = size; b.dstid = srcid;
        if (wen) begin
          for (int k = 0; k < 8; k++)
            if (wmask[k]) mm[sel][idx][8*k +: 8] = wdata[8*k +: 8];
          b.rdata = '0; b.ren = 1'b0;
          exp_q.push_back(b);
        end else begin
          n = (size >= 3'd4 && size <= 3'd6) ? (1 << (int'(size) - 3)) : 1;
          for (int k = 0; k < n; k++) begin
            b.rdata = mm[sel][(idx + k) % DEPTH]; b.ren = 1'b1;
            exp_q.push_back(b);
          end
        end
        busy = 1; t_first = cyc + 1 + lat; acc_cyc = cyc; first_pend = 1;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic w, input logic [63:0] d,
                       input logic [7:0] m, input logic [2:0] s, input logic [4:0] id);
    int t = 0;
    log_q.delete();
    beats_done = 0;
    @(posedge clk); #1;
    addr = a; wen = w; wdata = d; wmask = m; size = s; srcid = id; req_v = 1'b1;
    forever begin
      @(negedge clk);
      if (m_ready) break;
      t++;
      if (t > 50) begin
        checks++; failures++;
        $display("FAIL accept_timeout: got no req_ready expected accept within 50 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    req_v = 1'b0;
  endtask

  task automatic drain(input int pct, input int st_at, input int st_n);
    int t = 0, st = 0;
    while (busy && t < 200) begin
      @(posedge clk); #1;
      t++;
      if (beats_done == st_at && st < st_n) begin resp_r = 1'b0; st++; end
      else resp_r = ($urandom_range(99) < pct);
    end
    if (busy) begin
      checks++; failures++;
      $display("FAIL drain_timeout: got busy after 200 cycles expected all beats consumed");
    end
  endtask

  task automatic xact(input logic [31:0] a, input logic w, input logic [63:0] d, input logic [7:0] m,
                      input logic [2:0] s, input logic [4:0] id, input int pct, input int st_at, input int st_n);
    issue(a, w, d, m, s, id);
    drain(pct, st_at, st_n);
  endtask

  task automatic wr(input int word, input logic [63:0] d);
    xact(BASE + 32'(8 * word), 1'b1, d, 8'hFF, 3'd3, 5'd0, 100, -1, 0);
  endtask

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = ($urandom_range(3) == 0) ? $urandom() : BASE + 32'($urandom_range(1023));
      xact(a, 1'($urandom_range(1)), {$urandom(), $urandom()}, 8'($urandom()), 3'($urandom()),
           5'($urandom()), $urandom_range(100, 30), -1, 0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst_ready%0d", s), rdy_w[s], 1'b1);
      chk($sformatf("rst_valid%0d", s), vld_w[s], 1'b0);
      chk($sformatf("rst_rdata%0d", s), rdata_w[s], 64'h0);
      chk($sformatf("rst_ren%0d", s), ren_w[s], 1'b0);
      chk($sformatf("rst_size%0d", s), rsize_w[s], 3'd0);
      chk($sformatf("rst_dstid%0d", s), dstid_w[s], 5'd0);
    end

    // Known contents everywhere so random reads are predictable.
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int i = 0; i < DEPTH; i++) wr(i, {$urandom(), $urandom()});
    end

    sel = 1'b0;
    xact(32'h8000_0010, 1'b1, 64'h1122334455667788, 8'hFF, 3'd3, 5'd3, 100, -1, 0);
    chk("ack_latency", first_lat, 3);
    chk("ack_ren", log_q[0].ren, 1'b0);
    chk("ack_dstid", log_q[0].dstid, 5'd3);
    xact(32'h8000_0010, 1'b0, '0, '0, 3'd3, 5'd3, 100, -1, 0);
    chk("rd_full", log_q[0].rdata, 64'h1122334455667788);
    xact(32'h8000_0010, 1'b1, 64'hAABBCCDDEEFF0011, 8'h0F, 3'd3, 5'd4, 100, -1, 0);
    xact(32'h8000_0010, 1'b0, '0, '0, 3'd3, 5'd4, 100, -1, 0);
    chk("rd_partial", log_q[0].rdata, 64'h11223344EEFF0011);

    for (int i = 0; i < 4; i++) wr(i, 64'hA0 + 64'(i));
    xact(BASE, 1'b0, '0, '0, 3'd5, 5'd9, 100, -1, 0);
    chk("burst_nbeats", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++)
      chk($sformatf("burst_b%0d", i), log_q[i].rdata, 64'hA0 + 64'(i));
    xact(BASE, 1'b0, '0, '0, 3'd5, 5'd10, 100, 1, 5);
    chk("stall_nbeats", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++)
      chk($sformatf("stall_b%0d", i), log_q[i].rdata, 64'hA0 + 64'(i));

    for (int i = 0; i < 8; i++) wr((DEPTH - 3 + i) % DEPTH, 64'hB0 + 64'(i));
    xact(BASE + 32'(8 * (DEPTH - 3)), 1'b0, '0, '0, 3'd6, 5'd11, 100, -1, 0);
    chk("wrap_nbeats", log_q.size(), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++)
      chk($sformatf("wrap_b%0d", i), log_q[i].rdata, 64'hB0 + 64'(i));

    rand_phase(150);

    sel = 1'b1;
    xact(BASE + 32'd40, 1'b0, '0, '0, 3'd3, 5'd1, 100, -1, 0);
    chk("lat0_first", first_lat, 1);

    // Reset during a burst.
    resp_r = 1'b1;
    issue(BASE, 1'b0, '0, '0, 3'd6, 5'd2);
    @(posedge clk); #1 resp_r = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_burst_valid", m_valid, 1'b0);
    chk("rst_burst_ready", m_ready, 1'b1);

    // Reset while a write ack is pending: the write itself must persist.
    issue(BASE + 32'd56, 1'b1, 64'h00C0FFEE_DEADBEEF, 8'hFF, 3'd3, 5'd5);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    xact(BASE + 32'd56, 1'b0, '0, '0, 3'd3, 5'd6, 100, -1, 0);
    chk("rst_wr_kept", log_q[0].rdata, 64'h00C0FFEE_DEADBEEF);

    rand_phase(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
